// File: rtl/chi_link_pkg.sv
// Shared CHI link-layer definitions: link-state encodings, L-credit limit and
// link-flit opcode. Reused by the TX and RX link channels.
package chi_link_pkg;

   localparam logic [1:0] LINK_STOP       = 2'd0;
   localparam logic [1:0] LINK_ACTIVATE   = 2'd1;
   localparam logic [1:0] LINK_RUN        = 2'd2;
   localparam logic [1:0] LINK_DEACTIVATE = 2'd3;

   localparam int unsigned CHI_MAX_LCRD       = 15;
   localparam int unsigned LCRD_RETURN_OPCODE = 0;

   // LINKACTIVEREQ is asserted while heading for, or sitting in, ACTIVATE/RUN.
   function automatic logic link_req_for(input logic [1:0] st);
      return (st == LINK_ACTIVATE) || (st == LINK_RUN);
   endfunction

   // FLITPEND covers every state in which a flit may still be driven.
   function automatic logic link_pend_for(input logic [1:0] st);
      return (st == LINK_RUN) || (st == LINK_DEACTIVATE);
   endfunction

endpackage

// File: rtl/chi_link_credit_cnt.sv
// Saturating up/down L-credit counter with a sticky overflow flag.
// A simultaneous increment and decrement leaves the count unchanged.
module chi_link_credit_cnt
   import chi_link_pkg::*;
#(
   parameter int unsigned MAX_CREDITS = CHI_MAX_LCRD,
   parameter int unsigned CNT_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 inc_i,
   input  logic                 dec_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 ovf_o
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CREDITS);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   always_comb begin
      // NOTE: defaults first so every path assigns cnt_d/ovf_d; no latch is inferred.
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (inc_i && !dec_i) begin
         if (cnt_q == MAX_CNT) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!resetn) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/chi_link_tx_chan.sv
// CHI link-layer TX channel: link activation FSM, L-credit accounting, flit
// transmit and credit return. Optional counters under CHI_LINK_TX_PERF_CNT_EN.
module chi_link_tx_chan
   import chi_link_pkg::*;
#(
   parameter int unsigned FLIT_WIDTH  = 65,
   parameter int unsigned MAX_CREDITS = CHI_MAX_LCRD,
   parameter int unsigned CNT_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  link_en,
   input  logic                  flit_in_valid,
   output logic                  flit_in_ready,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   output logic                  CHI_TXLINKACTIVEREQ,
   input  logic                  CHI_TXLINKACTIVEACK,
   output logic                  CHI_TXFLITPEND,
   output logic                  CHI_TXFLITV,
   output logic [FLIT_WIDTH-1:0] CHI_TXFLIT,
   input  logic                  CHI_TXLCRDV,
   output logic [CNT_WIDTH-1:0]  credit_cnt,
   output logic [1:0]            link_state,
   output logic                  credit_ovf
`ifdef CHI_LINK_TX_PERF_CNT_EN
   ,
   output logic [31:0]           tx_flit_cnt,
   output logic [31:0]           tx_stall_cnt
`endif
);

   localparam logic [FLIT_WIDTH-1:0] LINK_FLIT = FLIT_WIDTH'(LCRD_RETURN_OPCODE);

   logic [1:0]            state_q, state_d;
   logic                  req_q, pend_q;
   logic                  flitv_q, flitv_d;
   logic [FLIT_WIDTH-1:0] flit_q, flit_d;

   logic credit_zero;
   logic accept;
   logic link_ret;
   logic send;
   logic lcrd_inc;

   assign credit_zero   = (credit_cnt == '0);
   assign flit_in_ready = (state_q == LINK_RUN) && !credit_zero;
   assign accept        = flit_in_valid && flit_in_ready;
   assign link_ret      = (state_q == LINK_DEACTIVATE) && !credit_zero;
   assign send          = accept || link_ret;
   assign lcrd_inc      = CHI_TXLCRDV && (state_q != LINK_STOP);

   always_comb begin
      state_d = state_q;
      case (state_q)
         LINK_STOP:       if (link_en && !CHI_TXLINKACTIVEACK) state_d = LINK_ACTIVATE;
         LINK_ACTIVATE:   if (CHI_TXLINKACTIVEACK)             state_d = LINK_RUN;
         LINK_RUN:        if (!link_en)                        state_d = LINK_DEACTIVATE;
         LINK_DEACTIVATE: if (!CHI_TXLINKACTIVEACK && credit_zero) state_d = LINK_STOP;
      endcase
   end

   // Accept and link return are mutually exclusive (RUN vs DEACTIVATE).
   always_comb begin
      flitv_d = send;
      flit_d  = flit_q;
      if (accept) begin
         flit_d = flit_in;
      end else if (link_ret) begin
         flit_d = LINK_FLIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= LINK_STOP;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
         flitv_q <= 1'b0;
         // NOTE: the flit data register is reset on purpose: CHI_TXFLIT must read 0 after reset.
         flit_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= link_req_for(state_d);
         pend_q  <= link_pend_for(state_d);
         flitv_q <= flitv_d;
         flit_q  <= flit_d;
      end
   end

   chi_link_credit_cnt #(
      .MAX_CREDITS (MAX_CREDITS),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_credit_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc_i  (lcrd_inc),
      .dec_i  (send),
      .cnt_o  (credit_cnt),
      .ovf_o  (credit_ovf)
   );

   assign CHI_TXLINKACTIVEREQ = req_q;
   assign CHI_TXFLITPEND      = pend_q;
   assign CHI_TXFLITV         = flitv_q;
   assign CHI_TXFLIT          = flit_q;
   assign link_state          = state_q;

`ifdef CHI_LINK_TX_PERF_CNT_EN
   logic [31:0] flit_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept) begin
            flit_cnt_q <= flit_cnt_q + 32'd1;
         end
         if (flit_in_valid && (state_q == LINK_RUN) && credit_zero) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign tx_flit_cnt  = flit_cnt_q;
   assign tx_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/chi_link_tx_chan.md
Name: chi_link_tx_chan

Overview:
- Generic CHI link-layer transmit channel: takes protocol flits from the bridge buffer over valid/ready and drives them onto a CHI TX channel (FLITPEND/FLITV/FLIT/LCRDV).
- Owns the TX link-activation FSM, L-credit accounting and credit return on deactivation.
- One instance per TX channel. In an RN-F bridge these are REQ, RSP and DAT; in an HN-F bridge they are SNP, RSP and DAT.

Parameters:
- FLIT_WIDTH, 65, flit width in bits (channel width computed by the instantiating top).
- MAX_CREDITS, 15, maximum L-credits held (CHI limit 15); range 1..15.
- CNT_WIDTH, 4, credit counter width, >= clog2(MAX_CREDITS+1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- link_en  in  1  register-driven request to bring the TX link up (1) or down (0)
- flit_in_valid  in  1  upstream flit valid
- flit_in_ready  out  1  upstream flit accepted when valid&ready
- flit_in  in  FLIT_WIDTH  upstream flit
- CHI_TXLINKACTIVEREQ  out  1  link activation request
- CHI_TXLINKACTIVEACK  in  1  link activation acknowledge
- CHI_TXFLITPEND  out  1  flit pending
- CHI_TXFLITV  out  1  flit valid
- CHI_TXFLIT  out  FLIT_WIDTH  flit
- CHI_TXLCRDV  in  1  L-credit grant from receiver
- credit_cnt  out  CNT_WIDTH  credits currently held
- link_state  out  2  FSM state (STOP=0, ACTIVATE=1, RUN=2, DEACTIVATE=3)
- credit_ovf  out  1  sticky: credit received while at MAX_CREDITS

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=STOP, credit_cnt=0, credit_ovf=0.
  - All CHI outputs 0; CHI_TXFLIT=0; flit_in_ready=0.
  - Applies mid-operation too: any in-flight flit is dropped.
- FSM:
  - STOP: REQ=0. Go to ACTIVATE when link_en=1 and ACK=0.
  - ACTIVATE: REQ=1. Go to RUN when ACK=1.
  - RUN: REQ=1. Go to DEACTIVATE when link_en=0.
  - DEACTIVATE: REQ=0. Go to STOP when ACK=0 and credit_cnt=0.
  - link_en toggling inside ACTIVATE is ignored until RUN is reached.
- CHI_TXLINKACTIVEREQ is registered and equals (next state is ACTIVATE or RUN).
- Credits:
  - LCRDV counts +1 in ACTIVATE, RUN and DEACTIVATE; it is ignored in STOP.
  - Each transmitted flit, protocol or link, counts -1.
  - LCRDV and a send in the same cycle leave the count unchanged.
  - LCRDV at MAX_CREDITS with no send: count holds and credit_ovf is set.
- Upstream handshake:
  - flit_in_ready = (state==RUN) && (credit_cnt!=0). Combinational from registers only; it does not depend on flit_in_valid.
  - A credit arriving while credit_cnt=0 makes ready high on the next cycle.
- TX timing:
  - A flit accepted in cycle N appears on CHI_TXFLITV/CHI_TXFLIT in cycle N+1. This gives back-to-back throughput of one flit per cycle.
  - CHI_TXFLIT holds its last value when FLITV=0.
  - CHI_TXFLITPEND is registered and is 1 in RUN and DEACTIVATE, 0 otherwise. This satisfies the one-cycle-ahead pend rule.
- Credit return:
  - In DEACTIVATE, while credit_cnt!=0, emit one link flit per cycle: FLITV=1 with FLIT all zeros (opcode 0 = LCrdReturn).
  - Each link flit decrements credit_cnt.
  - Credits arriving during DEACTIVATE are also returned.
  - flit_in_ready=0 throughout DEACTIVATE.
- A protocol flit accepted in the last RUN cycle is still driven in the first DEACTIVATE cycle. Credit return starts the following cycle.

Optional Feature:
- Macro: CHI_LINK_TX_PERF_CNT_EN.
- When defined, the block adds two output ports:
  - tx_flit_cnt (32 bits): increments on each protocol flit sent; link flits are excluded.
  - tx_stall_cnt (32 bits): increments each cycle with flit_in_valid=1 && state==RUN && credit_cnt=0.
  - Both counters wrap at 2^32 and clear on reset.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package chi_link_pkg holds:
  - link-state encodings (STOP/ACTIVATE/RUN/DEACTIVATE);
  - CHI_MAX_LCRD=15;
  - LCRD_RETURN_OPCODE=0.
  - The package is reused by the future chi_link_rx_chan.
- One sub-module, chi_link_credit_cnt, contains the saturating up/down credit counter with its overflow flag.

Test Plan:
- Bring-up: link_en=1, ACK rises 3 cycles after REQ → states STOP→ACTIVATE→RUN; REQ=1; FLITPEND=1 in RUN.
- Credits: 4 LCRDV pulses, then 6 valid flits back-to-back:
  - 4 flits appear on FLITV in consecutive cycles, each one cycle after acceptance;
  - ready drops at credit_cnt=0;
  - a 5th LCRDV releases flit 5 on the next cycle.
- Simultaneous: credit_cnt=2, LCRDV and acceptance in the same cycle → credit_cnt stays 2.
- Overflow: 16 LCRDV pulses with no traffic → credit_cnt=15, credit_ovf=1 and stays set.
- Deactivate: credit_cnt=3, link_en=0:
  - REQ drops;
  - 3 zero flits with FLITV=1 are emitted in 3 cycles;
  - credit_cnt=0;
  - ACK falls → STOP, FLITPEND=0.
- Reset mid-traffic: resetn=0 during RUN with credits 5 → next cycle all outputs 0, credit_cnt=0, state=STOP.
